arbitro_memoria_dados: RTL and testbench

ARBITRO_MEMORIA_DADOS -- requirements
Module: arbitro_memoria_dados

---
 rtl/arbitro_memoria_dados.sv | 162 ++++++++++++++++
 tb/tb_arbitro_memoria_dados.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_dados.sv
// Data-memory arbiter between processor (P) and loader/debug (C): grant at E0, mem strobe E0..E1, ack E2..E3.
// ARB_ROUND_ROBIN_EN selects round-robin on conflict; otherwise P has fixed priority.
module arbitro_memoria_dados #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_p,
  input  logic              req_c,
  input  logic              we_p,
  input  logic              we_c,
  input  logic [ADDR_W-1:0] addr_p,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] wdata_p,
  input  logic [DATA_W-1:0] wdata_c,
  output logic              gnt_p,
  output logic              gnt_c,
  output logic              ack_p,
  output logic              ack_c,
  output logic [DATA_W-1:0] rdata_p,
  output logic [DATA_W-1:0] rdata_c,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        conflitos
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ACESSO   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  estado_t            estado, estado_n;
  logic               gnt_p_n, gnt_c_n;
  logic               ack_p_n, ack_c_n;
  logic [DATA_W-1:0]  rdata_p_n, rdata_c_n;
  logic               mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]  mem_addr_n;
  logic [DATA_W-1:0]  mem_wdata_n;
  logic [7:0]         conflitos_n;
  logic               we_lat, we_lat_n;
  logic               eleg_p, eleg_c, vence_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic               prio_c, prio_c_n;
`endif

  // A requester being acked this cycle still has req high but was already served.
  assign eleg_p = req_p & ~ack_p;
  assign eleg_c = req_c & ~ack_c;

`ifdef ARB_ROUND_ROBIN_EN
  assign vence_c = eleg_c & (~eleg_p | prio_c);
`else
  assign vence_c = eleg_c & ~eleg_p;
`endif

  always_comb begin
    estado_n    = estado;
    gnt_p_n     = gnt_p;
    gnt_c_n     = gnt_c;
    ack_p_n     = 1'b0;
    ack_c_n     = 1'b0;
    rdata_p_n   = rdata_p;
    rdata_c_n   = rdata_c;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    conflitos_n = conflitos;
    we_lat_n    = we_lat;
`ifdef ARB_ROUND_ROBIN_EN
    prio_c_n    = prio_c;
`endif

    case (estado)
      OCIOSO: begin
        if (eleg_p || eleg_c) begin
          gnt_p_n     = ~vence_c;
          gnt_c_n     = vence_c;
          mem_en_n    = 1'b1;
          mem_we_n    = vence_c ? we_c    : we_p;
          we_lat_n    = vence_c ? we_c    : we_p;
          mem_addr_n  = vence_c ? addr_c  : addr_p;
          mem_wdata_n = vence_c ? wdata_c : wdata_p;
          estado_n    = ACESSO;
          if (eleg_p && eleg_c && (conflitos != 8'hFF))
            conflitos_n = conflitos + 8'd1;
`ifdef ARB_ROUND_ROBIN_EN
          prio_c_n    = ~vence_c;
`endif
        end
      end

      ACESSO: begin
        estado_n = RESPOSTA;
      end

      RESPOSTA: begin
        gnt_p_n = 1'b0;
        gnt_c_n = 1'b0;
        ack_p_n = gnt_p;
        ack_c_n = gnt_c;
        // Synchronous memory data is valid now, one cycle after the strobe.
        if (!we_lat) begin
          if (gnt_p) rdata_p_n = mem_rdata;
          if (gnt_c) rdata_c_n = mem_rdata;
        end
        estado_n = OCIOSO;
      end

      default: begin
        estado_n = OCIOSO;
        gnt_p_n  = 1'b0;
        gnt_c_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      gnt_p     <= 1'b0;
      gnt_c     <= 1'b0;
      ack_p     <= 1'b0;
      ack_c     <= 1'b0;
      rdata_p   <= '0;
      rdata_c   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      conflitos <= 8'd0;
      we_lat    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      prio_c    <= 1'b0;
`endif
    end else begin
      estado    <= estado_n;
      gnt_p     <= gnt_p_n;
      gnt_c     <= gnt_c_n;
      ack_p     <= ack_p_n;
      ack_c     <= ack_c_n;
      rdata_p   <= rdata_p_n;
      rdata_c   <= rdata_c_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      conflitos <= conflitos_n;
      we_lat    <= we_lat_n;
`ifdef ARB_ROUND_ROBIN_EN
      prio_c    <= prio_c_n;
`endif
    end
  end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Scoreboard bench for arbitro_memoria_dados: transaction-level reference model plus a behavioural sync memory.
module tb_arbitro_memoria_dados;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_p, req_c, we_p, we_c;
  logic [AW-1:0] addr_p, addr_c;
  logic [DW-1:0] wdata_p, wdata_c;
  logic          gnt_p, gnt_c, ack_p, ack_c;
  logic [DW-1:0] rdata_p, rdata_c;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [7:0]    conflitos;

  arbitro_memoria_dados #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .req_p(req_p), .req_c(req_c), .we_p(we_p), .we_c(we_c),
    .addr_p(addr_p), .addr_c(addr_c), .wdata_p(wdata_p), .wdata_c(wdata_c),
    .gnt_p(gnt_p), .gnt_c(gnt_c), .ack_p(ack_p), .ack_c(ack_c),
    .rdata_p(rdata_p), .rdata_c(rdata_c),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflitos(conflitos)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 3) ? 16'h00A5 : 16'((a * 257) ^ 16'h5A3C);
  endfunction

  // Behavioural synchronous memory: untouched words return their initial pattern.
  logic [DW-1:0] mem  [0:255];
  bit            wrtn [0:255];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr]  <= mem_wdata;
        wrtn[mem_addr] <= 1'b1;
      end
      mem_rdata <= wrtn[mem_addr] ? mem[mem_addr] : init_val(int'(mem_addr));
    end
  end

  typedef struct {
    int            who;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            cyc;
  } txn_t;

  txn_t sbq[$];
  txn_t memq[$];

  // Reference model: a grant at edge e occupies the memory until e+3, acks at e+2.
  logic [DW-1:0] ref_mem [0:255];
  logic [DW-1:0] last_rd [2];
  int next_free = 0;
  int acked     = -1;
  int gwho      = -1;
  int gstart    = 0;
  int conf      = 0;
  bit prio_c    = 1'b0;

  // Requester drivers (index 0 = P, 1 = C).
  bit            act [2];
  bit            grt [2];
  int            ackc[2];
  bit            rq  [2];
  bit            wer [2];
  logic [AW-1:0] ad  [2];
  logic [DW-1:0] wd  [2];
  bit            pend[2];
  bit            pwe [2];
  logic [AW-1:0] pad [2];
  logic [DW-1:0] pwd [2];

  assign req_p = rq[0];  assign req_c = rq[1];
  assign we_p  = wer[0]; assign we_c  = wer[1];
  assign addr_p = ad[0]; assign addr_c = ad[1];
  assign wdata_p = wd[0]; assign wdata_c = wd[1];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    memq.delete();
    next_free = 0;
    acked = -1;
    gwho = -1;
    conf = 0;
    prio_c = 1'b0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int x = 0; x < 2; x++) begin
      act[x] = 0; grt[x] = 0; rq[x] = 0; pend[x] = 0;
    end
  endtask

  task automatic decide();
    int e;
    int w;
    bit ep, ec;
    txn_t t;
    e = cyc + 1;
    if (e < next_free) return;
    ep = rq[0] && !(e == next_free && acked == 0);
    ec = rq[1] && !(e == next_free && acked == 1);
    if (!ep && !ec) return;
    if (ep && ec && conf < 255) conf++;
`ifdef ARB_ROUND_ROBIN_EN
    w = (ep && ec) ? (prio_c ? 1 : 0) : (ep ? 0 : 1);
    prio_c = (w == 0);
`else
    w = ep ? 0 : 1;
`endif
    t.who = w; t.we = wer[w]; t.addr = ad[w]; t.wdata = wd[w]; t.rdata = '0; t.cyc = e;
    memq.push_back(t);
    if (t.we) begin
      ref_mem[t.addr] = t.wdata;
      t.rdata = last_rd[w];
    end else begin
      t.rdata = ref_mem[t.addr];
      last_rd[w] = t.rdata;
    end
    t.cyc = e + 2;
    sbq.push_back(t);
    next_free = e + 3; acked = w; gwho = w; gstart = e;
    grt[w] = 1; ackc[w] = e + 2;
  endtask

  task automatic issue(input int x, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[x] = 1; pwe[x] = we; pad[x] = a; pwd[x] = d;
  endtask

  // One clock: retire acked requests, start new ones, scramble fields of granted ones.
  task automatic cycle(input int pp, input int pc);
    int pct;
    @(negedge clock); #1;
    for (int x = 0; x < 2; x++) begin
      pct = (x == 0) ? pp : pc;
      if (act[x] && grt[x] && cyc == ackc[x]) act[x] = 0;
      if (!act[x] && pend[x]) begin
        act[x] = 1; grt[x] = 0; rq[x] = 1; pend[x] = 0;
        wer[x] = pwe[x]; ad[x] = pad[x]; wd[x] = pwd[x];
      end else if (!act[x] && pct > 0 && int'($urandom_range(99)) < pct) begin
        act[x] = 1; grt[x] = 0; rq[x] = 1;
        wer[x] = 1'($urandom_range(1)); ad[x] = 8'($urandom_range(15)); wd[x] = 16'($urandom);
      end else if (!act[x]) begin
        rq[x] = 0;
      end else if (grt[x]) begin
        wer[x] = 1'($urandom_range(1)); ad[x] = 8'($urandom); wd[x] = 16'($urandom);
      end
    end
    decide();
  endtask

  // Monitor: compares every output against the model once per cycle.
  always @(negedge clock) begin
    bit exp_en, exp_ack;
    exp_en = 0;
    exp_ack = 0;
    chk("gnt_p", 32'(gnt_p), 32'(gwho == 0 && cyc >= gstart && cyc < gstart + 2));
    chk("gnt_c", 32'(gnt_c), 32'(gwho == 1 && cyc >= gstart && cyc < gstart + 2));
    if (memq.size() > 0) exp_en = (memq[0].cyc == cyc);
    chk("mem_en", 32'(mem_en), 32'(exp_en));
    if (exp_en) begin
      chk("mem_we", 32'(mem_we), 32'(memq[0].we));
      chk("mem_addr", 32'(mem_addr), 32'(memq[0].addr));
      if (memq[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(memq[0].wdata));
      void'(memq.pop_front());
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'(0));
    end
    if (sbq.size() > 0) exp_ack = (sbq[0].cyc == cyc);
    chk("ack_p", 32'(ack_p), 32'(exp_ack && sbq[0].who == 0));
    chk("ack_c", 32'(ack_c), 32'(exp_ack && sbq[0].who == 1));
    if (exp_ack) begin
      if (sbq[0].who == 0) chk("rdata_p", 32'(rdata_p), 32'(sbq[0].rdata));
      else                 chk("rdata_c", 32'(rdata_c), 32'(sbq[0].rdata));
      void'(sbq.pop_front());
    end
    chk("conflitos", 32'(conflitos), 32'(conf));
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'({gnt_p, gnt_c}), 32'(0));
    chk({tag, "_ack"}, 32'({ack_p, ack_c}), 32'(0));
    chk({tag, "_strobe"}, 32'({mem_en, mem_we}), 32'(0));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
    chk({tag, "_rdata"}, {rdata_p, rdata_c}, 32'(0));
    chk({tag, "_conflitos"}, 32'(conflitos), 32'(0));
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    repeat (2) @(negedge clock);
    #1 chk_zero("reset");
    #1 reset = 1'b1;

    // Single read of 0x00A5 at address 3 by P.
    issue(0, 1'b0, 8'd3, 16'h0);
    repeat (7) cycle(0, 0);
    chk("read_a5", 32'(rdata_p), 32'h00A5);
    chk("read_noconf", 32'(conflitos), 32'(0));

    // Single write by C: rdata_c keeps its previous value.
    issue(1, 1'b1, 8'd5, 16'h1234);
    repeat (7) cycle(0, 0);
    chk("write_rdata_c", 32'(rdata_c), 32'(0));
    chk("write_mem5", 32'({wrtn[5], mem[5]}), 32'h11234);

    // Conflict, then both requesters held continuously.
    c0 = int'(conflitos);
    issue(0, 1'b0, 8'd3, 16'h0);
    issue(1, 1'b0, 8'd5, 16'h0);
    repeat (40) cycle(100, 100);
    repeat (10) cycle(0, 0);
    chk("conflict_once", 32'(conflitos), 32'(c0 + 1));

    // Back-to-back P with req held: spacing enforced by the scoreboard ack cycles.
    repeat (40) cycle(100, 0);
    repeat (10) cycle(0, 0);

    // Reset during ACESSO abandons the read.
    issue(0, 1'b0, 8'd7, 16'h0);
    cycle(0, 0);
    @(negedge clock); #2;
    chk("pre_reset_mem_en", 32'(mem_en), 32'(1));
    chk("pre_reset_gnt_p", 32'(gnt_p), 32'(1));
    reset = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    issue(0, 1'b0, 8'd3, 16'h0);
    repeat (8) cycle(0, 0);

    // Random traffic.
    repeat (2000) cycle(30, 30);
    repeat (10) cycle(0, 0);

    // Saturation: simultaneous requests from idle, each pair is one conflict.
    for (int i = 0; i < 300; i++) begin
      issue(0, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
      issue(1, 1'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom));
      repeat (8) cycle(0, 0);
    end
    chk("conflitos_sat", 32'(conflitos), 32'd255);

    repeat (10) cycle(0, 0);
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    chk("memq_drained", 32'(memq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
